// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and widths for the sequential multiplier
package mul_pkg;

    localparam int MUL_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        MUL    = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - sequencing controller for the repeated-addition multiplier datapath
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int W        = MUL_W,
    parameter bit SWAP_MIN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] data_out,
    output logic         ldA,
    output logic         ldB,
    output logic         clrP,
    output logic         ldP,
    output logic         decB,
    input  logic         eqz
);

    state_t       state_q;
    state_t       state_d;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         accept;
    logic         swap;

    assign accept = (state_q == IDLE) && start && !abort;
    // Putting the smaller operand in B bounds the loop at min(a,b) iterations.
    assign swap   = SWAP_MIN && (op_b > op_a);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q <= swap ? op_b : op_a;
                b_q <= swap ? op_a : op_b;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        busy     = (state_q != IDLE);
        done     = 1'b0;
        data_out = '0;
        ldA      = 1'b0;
        ldB      = 1'b0;
        clrP     = 1'b0;
        ldP      = 1'b0;
        decB     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = LOAD_A;
            end
            LOAD_A: begin
                data_out = a_q;
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    ldA     = 1'b1;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                data_out = b_q;
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    ldB     = 1'b1;
                    clrP    = 1'b1;
                    state_d = MUL;
                end
            end
            MUL: begin
                // eqz reflects B before this cycle's decrement, so the exit lags by one cycle.
                if (abort) begin
                    state_d = IDLE;
                end else if (!eqz) begin
                    ldP  = 1'b1;
                    decB = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - directed self-checking bench for mul_seq_ctrl with a behavioural datapath
module tb_mul_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] op_a = '0;
    logic [7:0] op_b = '0;

    logic       busy1, done1, ldA1, ldB1, clrP1, ldP1, decB1, eqz1;
    logic [7:0] data1;
    logic       busy0, done0, ldA0, ldB0, clrP0, ldP0, decB0, eqz0;
    logic [7:0] data0;

    logic [7:0]  ra1, rb1, ra0, rb0;
    logic [15:0] rp1, rp0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl #(.W(8), .SWAP_MIN(1'b1)) dut_swap (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .op_a(op_a), .op_b(op_b), .busy(busy1), .done(done1),
        .data_out(data1), .ldA(ldA1), .ldB(ldB1), .clrP(clrP1),
        .ldP(ldP1), .decB(decB1), .eqz(eqz1)
    );

    mul_seq_ctrl #(.W(8), .SWAP_MIN(1'b0)) dut_noswap (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .op_a(op_a), .op_b(op_b), .busy(busy0), .done(done0),
        .data_out(data0), .ldA(ldA0), .ldB(ldB0), .clrP(clrP0),
        .ldP(ldP0), .decB(decB0), .eqz(eqz0)
    );

    // Datapath without reset, as in the real multiplier.
    always_ff @(posedge clk) begin
        if (ldA1) ra1 <= data1;
        if (ldB1) rb1 <= data1;
        else if (decB1) rb1 <= rb1 - 8'd1;
        if (clrP1) rp1 <= '0;
        else if (ldP1) rp1 <= rp1 + {8'd0, ra1};
    end
    assign eqz1 = (rb1 == 8'd0);

    always_ff @(posedge clk) begin
        if (ldA0) ra0 <= data0;
        if (ldB0) rb0 <= data0;
        else if (decB0) rb0 <= rb0 - 8'd1;
        if (clrP0) rp0 <= '0;
        else if (ldP0) rp0 <= rp0 + {8'd0, ra0};
    end
    assign eqz0 = (rb0 == 8'd0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int lat1,
                          input int lat0, input int n, input logic [15:0] p, input string tag);
        int d1, d0, s_ldp, s_decb;
        logic [15:0] p1, p0;
        d1 = -1; d0 = -1; s_ldp = 0; s_decb = 0; p1 = '0; p0 = '0;
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b;
        for (int k = 1; k <= 400 && (d1 < 0 || d0 < 0); k++) begin
            @(negedge clk);
            start = 1'b0; op_a = ~a; op_b = ~b;
            if (ldP1) s_ldp++;
            if (decB1) s_decb++;
            if (done1 && d1 < 0) begin d1 = k; p1 = rp1; end
            if (done0 && d0 < 0) begin d0 = k; p0 = rp0; end
        end
        chk({tag, " done cycle swap"}, d1, lat1);
        chk({tag, " done cycle noswap"}, d0, lat0);
        chk({tag, " P swap"}, {16'd0, p1}, {16'd0, p});
        chk({tag, " P noswap"}, {16'd0, p0}, {16'd0, p});
        chk({tag, " ldP cycles"}, s_ldp, n);
        chk({tag, " decB cycles"}, s_decb, n);
        @(negedge clk);
        chk({tag, " done drops"}, {31'd0, done1 | done0}, 32'd0);
        chk({tag, " idle after"}, {31'd0, busy1 | busy0}, 32'd0);
    endtask

    initial begin
        int cnt;
        logic [15:0] pv;

        // Reset state
        #1;
        chk("reset busy", {31'd0, busy1}, 0);
        chk("reset done", {31'd0, done1}, 0);
        chk("reset strobes", {27'd0, ldA1, ldB1, clrP1, ldP1, decB1}, 0);
        chk("reset data_out", {24'd0, data1}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'd5, 8'd3, 7, 7, 3, 16'd15, "5x3");
        run_op(8'd3, 8'd200, 7, 204, 3, 16'd600, "3x200");
        run_op(8'd0, 8'd9, 4, 13, 0, 16'd0, "0x9");
        run_op(8'd9, 8'd0, 4, 4, 0, 16'd0, "9x0");
        run_op(8'd255, 8'd255, 259, 259, 255, 16'd65025, "255x255");

        // Abort in cycle 6 of a 10x10 operation
        cnt = 0;
        @(negedge clk);
        start = 1'b1; op_a = 8'd10; op_b = 8'd10;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            start = 1'b0;
            abort = (k == 6);
            #1;
            if (done1 || done0) cnt++;
            if (k == 6) begin
                chk("abort strobes off", {30'd0, ldP1, decB1}, 0);
                chk("abort busy in abort cycle", {31'd0, busy1}, 1);
            end
            if (k == 7) begin
                chk("abort idle swap", {31'd0, busy1}, 0);
                chk("abort idle noswap", {31'd0, busy0}, 0);
            end
        end
        abort = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done1 || done0) cnt++;
        end
        chk("abort no done", cnt, 0);
        run_op(8'd2, 8'd2, 6, 6, 2, 16'd4, "after abort 2x2");

        // Asynchronous reset mid-MUL
        @(negedge clk);
        start = 1'b1; op_a = 8'd50; op_b = 8'd50;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("rst busy", {30'd0, busy1, busy0}, 0);
        chk("rst strobes", {27'd0, ldA1, ldB1, clrP1, ldP1, decB1}, 0);
        chk("rst done/data", {23'd0, done1, data1}, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'd7, 8'd6, 10, 10, 6, 16'd42, "after rst 7x6");

        // start pulses while busy are ignored
        cnt = 0; pv = '0;
        @(negedge clk);
        start = 1'b1; op_a = 8'd4; op_b = 8'd3;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            start = (k <= 4);
            op_a = 8'd1; op_b = 8'd1;
            if (done1) begin cnt++; pv = rp1; end
        end
        chk("busy start done count", cnt, 1);
        chk("busy start P", {16'd0, pv}, 32'd12);

        // start held high: re-accepted in the cycle after DONE
        cnt = 0;
        @(negedge clk);
        start = 1'b1; op_a = 8'd2; op_b = 8'd1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (done1) cnt++;
            if (k == 5) chk("held done cycle", {31'd0, done1}, 1);
            if (k == 6) chk("held idle after done", {31'd0, busy1}, 0);
            if (k == 7) chk("held reaccepted", {31'd0, ldA1}, 1);
        end
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done1) begin cnt++; pv = rp1; end
        end
        chk("held done count", cnt, 2);
        chk("held second P", {16'd0, pv}, 32'd2);
        chk("held final idle", {30'd0, busy1, busy0}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequencing controller for the 8-bit repeated-addition multiplier datapath: A and B registers, a 16-bit product register P, and the B==0 comparator. It accepts an operand pair through a start/done handshake. It drives the shared `data_in` bus and the `ldA`/`ldB`/`clrP`/`ldP`/`decB` strobes, and runs the add/decrement loop until `eqz`. It sits between the issuing logic and the datapath in the multiplier top level.

## Interface
- `W`, 8: operand width; must match the datapath (8).
- `SWAP_MIN`, 1: when 1, the smaller operand is loaded into B so the loop runs min(a,b) times; when 0, `op_b` always goes to B.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request; sampled only in IDLE.
- `abort`, in, 1: synchronous cancel of an operation in progress.
- `op_a`, in, W: multiplicand; captured at start acceptance.
- `op_b`, in, W: multiplier; captured at start acceptance.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse; product on the datapath P is valid while high.
- `data_out`, out, W: drives datapath `data_in`.
- `ldA`, `ldB`, `clrP`, `ldP`, `decB`, out, 1 each: datapath strobes.
- `eqz`, in, 1: datapath B==0 flag (combinational from B).

## Operation
- States: IDLE, LOAD_A, LOAD_B, MUL, DONE. All are registered; strobes and `data_out` are decoded from the state.
- IDLE: all strobes 0, `data_out`=0. If `start`=1 and `abort`=0, capture the operands into internal registers and go to LOAD_A. Later changes on `op_a`/`op_b` have no effect.
- Operand order: if `SWAP_MIN`=1 and captured b > a, the operands are exchanged so that B=min and A=max. On a tie there is no swap.
- LOAD_A: `ldA`=1, `data_out`=A operand. Go to LOAD_B.
- LOAD_B: `ldB`=1, `clrP`=1, `data_out`=B operand. Go to MUL.
- MUL, eqz=0: `ldP`=1 and `decB`=1 in the same cycle (P+=A, B-=1). Stay in MUL.
- MUL, eqz=1: no strobes. Go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. P holds its value until the next LOAD_B.
- `abort`=1 in LOAD_A, LOAD_B or MUL: next state is IDLE, with no DONE and no `done` pulse. Strobes are 0 in the abort cycle. Datapath contents are left as-is and are undefined for software.
- `abort` in DONE has no effect; the pulse completes. `abort` in IDLE blocks `start` that cycle.
- `start` while busy is ignored and not queued.
- Arithmetic: the product is at most (2^W−1)^2 and fits 2W bits, so the datapath adder cannot overflow. The controller does no arithmetic beyond the swap compare.

## Timing
- Reset values: state=IDLE; `busy`, `done`, all strobes and `data_out` = 0; operand registers = 0.
- Reset mid-operation returns to IDLE immediately (asynchronous). The datapath has no reset, so P is undefined until the next `clrP`.
- Let n = number of loop iterations (B after swap). With `start` sampled in cycle 0:
  - LOAD_A in cycle 1.
  - LOAD_B in cycle 2.
  - MUL in cycles 3..3+n; strobes are active in cycles 3..2+n.
  - DONE in cycle 4+n.
- Start-to-done latency is n+4 cycles. Back-to-back: the next `start` can be accepted in cycle 5+n (IDLE).
- n=0: the first MUL cycle sees eqz=1, `done` asserts in cycle 4, and P=0.
- `eqz` is used only in MUL, never earlier; it is one cycle stale relative to `decB`, which is why the loop exits in cycle 3+n.

## Structure
- Shared package `mul_pkg`:
  - state enum with IDLE=0, LOAD_A, LOAD_B, MUL, DONE;
  - `MUL_W`=8.
- No sub-module inside the controller.
- The natural next level is a wrapper `mul_top` instantiating `mul_seq_ctrl` and the datapath. Benches exercise `mul_top` end-to-end and check `done` and P.

## Test plan
- Defaults, a=5, b=3: iterations=3, `done` in cycle 7, P=15. Check `ldP`/`decB` high for exactly 3 cycles.
- a=3, b=200: with `SWAP_MIN`=1, `done` in cycle 7 and P=600. With `SWAP_MIN`=0, `done` in cycle 204 and P=600.
- a=0, b=9, and a=9, b=0: `done` in cycle 4, P=0. Also a=255, b=255: `done` in cycle 259, P=65025.
- Start a=10, b=10; assert `abort` in cycle 6: no `done` pulse, IDLE in cycle 7. A new start a=2, b=2 then gives P=4 with `done` 6 cycles after acceptance.
- Assert `rst` mid-MUL: all outputs 0 immediately, `busy`=0. After release, start a=7, b=6 gives P=42.
- Pulse `start` with a=1, b=1 while busy: ignored, with exactly one `done` per accepted start. `start` held high continuously: accepted again in the cycle after DONE.
